i2s_sample_tx: RTL
==================

# i2s_sample_tx

I2S serializer for the audio path. It accepts stereo PCM frames through a valid/ready handshake and buffers them in a small frame FIFO. It shifts the samples out on `sdata_out`, aligned to the BCLK/LRCLK pair generated by the audio clock generator. It runs entirely in the `clk_in` (50 MHz) domain and treats BCLK/LRCLK as asynchronous inputs that it synchronizes and edge-detects.

## Interface
- `SAMPLE_W`, 16: PCM sample width. Must be ≤ `SLOT_W`.
- `SLOT_W`, 32: BCLK periods per channel slot. A frame is 64 BCLK.
- `FIFO_DEPTH`, 4: frame FIFO depth, in stereo frames. Must be a power of 2.
- `clk_in`  in  1  system clock, 50 MHz.
- `reset_n`  in  1  reset: asynchronous, active-low.
- `bclk_in`  in  1  I2S bit clock, 2.8224 MHz nominal, asynchronous.
- `lrclk_in`  in  1  I2S word select, asynchronous. 0 = left, 1 = right.
- `enable`  in  1  transmit enable. Sampled only at left-slot boundaries.
- `s_valid`  in  1  frame offered.
- `s_ready`  out  1  FIFO not full.
- `s_left`  in  SAMPLE_W  left sample, two's complement.
- `s_right`  in  SAMPLE_W  right sample, two's complement.
- `sdata_out`  out  1  I2S serial data.
- `underrun`  out  1  one-cycle pulse: FIFO empty at a left boundary while enabled.
- `frame_start`  out  1  one-cycle pulse at each left-slot boundary.
- `fifo_level`  out  $clog2(FIFO_DEPTH+1)  frames currently buffered.

## Operation
- **Synchronizers:** `bclk_in` and `lrclk_in` each pass through a 2-FF synchronizer. `bclk_fall` = synced BCLK is 0 now and was 1 in the previous cycle.
- **Per-bit event:** everything below happens only on a cycle where `bclk_fall` is 1.
- **Slot boundary:** `lr_prev` holds synced LRCLK as captured at the previous `bclk_fall`. A boundary is synced LRCLK ≠ `lr_prev`. A left boundary is a 1→0 change; a right boundary is a 0→1 change.
- **Shift register `shreg`** (SLOT_W wide), on every `bclk_fall`:
  - `sdata_out` ← `shreg[SLOT_W-1]`, then `shreg` shifts left with zero fill.
  - On a boundary, `shreg` is loaded instead of shifted. The sample goes in the top SAMPLE_W bits, zero padding below.
  - Effect: the MSB appears one BCLK after the LRCLK edge (I2S delay). Bits after the LSB are 0.
- **Left boundary, `enable`=1, FIFO non-empty:**
  - Pop one frame.
  - Load `s_left` into `shreg`.
  - Latch `s_right` into `hold_r`.
  - Pulse `frame_start`.
- **Left boundary, `enable`=1, FIFO empty:**
  - Load 0 into `shreg` and 0 into `hold_r`.
  - Pulse `underrun` and `frame_start`.
- **Left boundary, `enable`=0:**
  - Load 0 into `shreg` and 0 into `hold_r`.
  - No pop, no `underrun`. `frame_start` still pulses.
- **Right boundary:** load `hold_r` into `shreg`.
- **Push:** `s_valid && s_ready` writes {left, right} to the FIFO. `s_ready` = !full.
- **Simultaneous push and pop:**
  - Non-empty FIFO: both happen; `fifo_level` is unchanged.
  - Empty FIFO: the pop sees empty, so `underrun` pulses and the pushed frame is kept.
- **Startup:** after reset, output stays 0 until the first left boundary is detected. A partial first frame is discarded.

## Timing
- **Reset values:**
  - `sdata_out`=0, `underrun`=0, `frame_start`=0, `fifo_level`=0, `s_ready`=1.
  - `shreg`=0, `hold_r`=0, synchronizers=0, `lr_prev`=0.
- **Latency:** `sdata_out` changes exactly 3 `clk_in` cycles after a BCLK falling edge at the pin (2 synchronizer stages + 1 register).
- **Clock ratio:** requires each BCLK half-period ≥ 3 `clk_in` cycles. Nominal is ≈8.8.
- **Pulse alignment:** `underrun` and `frame_start` assert in the same cycle `sdata_out` updates.
- **FIFO flags:**
  - `s_ready` falls the cycle after the push that fills the FIFO.
  - `s_ready` rises the cycle after a pop from a full FIFO.
  - `fifo_level` updates one cycle after the push or pop.
- **Mid-operation reset:** all outputs return to their reset values immediately (asynchronously) and the FIFO is emptied.

## Structure
- **Package `audio_pkg`:**
  - `SAMPLE_W`, `SLOT_W`, `FRAME_BCLKS`=64.
  - Constants `I2S_LEFT`=0, `I2S_RIGHT`=1.
  - Type `audio_frame_t` {left, right}.
- **Sub-module `audio_frame_fifo`:** synchronous FIFO of `audio_frame_t` with wrap-around pointers, full/empty flags and a level count. The top level holds the synchronizers, boundary detect, shift register and handshake.

## Test plan
- **Reset:** apply reset with BCLK running → all outputs at reset values. After release, `sdata_out`=0 until the first 1→0 LRCLK edge.
- **Single frame:** push L=0xA5C3, R=0x1234, then run 64-BCLK frames → after LRCLK falls, one 0 bit, then 1010010111000011, then 15 zeros. The right slot carries 0001001000110100 with the same 1-bit delay. `fifo_level` goes 1→0.
- **Underrun:** empty FIFO at a left boundary with `enable`=1 → a full frame of zeros, `underrun` high for exactly 1 cycle, coincident with `frame_start`.
- **Backpressure:** push 5 frames with BCLK stopped → 4 accepted, `s_ready`=0, `fifo_level`=4. After one left boundary, `s_ready`=1 and `fifo_level`=3.
- **Enable gating:** `enable`=0 at a left boundary with 2 frames queued → zero frame, no pop (level stays 2), no `underrun`.
- **Mid-slot reset:** assert `reset_n` low after left-slot bit 7 → `sdata_out`=0 immediately and `fifo_level`=0. Transmission resumes only at the next full left boundary.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-path constants and the stereo frame type.
package audio_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int SLOT_W      = 32;
  localparam int FRAME_BCLKS = 2 * SLOT_W;

  // LRCLK level that selects each channel slot.
  localparam logic I2S_LEFT  = 1'b0;
  localparam logic I2S_RIGHT = 1'b1;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } audio_frame_t;

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous FIFO of stereo frames.
// The read data always shows the oldest entry, so a pop consumes the frame
// that is visible in the same cycle.
module audio_frame_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             push,
  input  audio_frame_t     wdata,
  input  logic             pop,
  output audio_frame_t     rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  audio_frame_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_sample_tx.sv
// I2S serializer: buffers stereo frames and shifts them out MSB first,
// one BCLK after each LRCLK edge, on falling edges of the synchronized BCLK.
module i2s_sample_tx #(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk_in,
  input  logic                             reset_n,
  input  logic                             bclk_in,
  input  logic                             lrclk_in,
  input  logic                             enable,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [SAMPLE_W-1:0]              s_left,
  input  logic [SAMPLE_W-1:0]              s_right,
  output logic                             sdata_out,
  output logic                             underrun,
  output logic                             frame_start,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

  import audio_pkg::*;

  localparam int PAD_W = SLOT_W - SAMPLE_W;

  logic                bclk_s1, bclk_s2, bclk_d;
  logic                lr_s1, lr_s2, lr_prev;
  logic                bclk_fall;
  logic                slot_bnd, left_bnd, right_bnd;
  logic                fifo_full, fifo_empty, fifo_pop, fifo_push;
  audio_frame_t        wr_frame, rd_frame;
  logic [SLOT_W-1:0]   shreg;
  logic [SAMPLE_W-1:0] hold_r;

  // Sample placed in the top bits of a slot, zero padding below.
  function automatic logic [SLOT_W-1:0] slot_word(input logic [SAMPLE_W-1:0] s);
    return SLOT_W'(s) << PAD_W;
  endfunction

  // Two-stage synchronizers for BCLK/LRCLK plus the previous synced BCLK.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      bclk_s1 <= 1'b0;
      bclk_s2 <= 1'b0;
      bclk_d  <= 1'b0;
      lr_s1   <= 1'b0;
      lr_s2   <= 1'b0;
    end else begin
      bclk_s1 <= bclk_in;
      bclk_s2 <= bclk_s1;
      bclk_d  <= bclk_s2;
      lr_s1   <= lrclk_in;
      lr_s2   <= lr_s1;
    end
  end

  assign bclk_fall = bclk_d && !bclk_s2;
  assign slot_bnd  = bclk_fall && (lr_s2 != lr_prev);
  assign left_bnd  = slot_bnd && (lr_prev == I2S_RIGHT) && (lr_s2 == I2S_LEFT);
  assign right_bnd = slot_bnd && (lr_s2 == I2S_RIGHT);

  // A frame leaves the FIFO only at an enabled left boundary with data present.
  assign fifo_pop  = left_bnd && enable && !fifo_empty;
  assign fifo_push = s_valid && s_ready;
  assign s_ready   = !fifo_full;
  assign wr_frame  = '{left: s_left, right: s_right};

  audio_frame_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   (wr_frame),
    .pop     (fifo_pop),
    .rdata   (rd_frame),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Per-BCLK serializer: output the MSB, then load at slot boundaries or shift.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      shreg       <= '0;
      hold_r      <= '0;
      lr_prev     <= 1'b0;
      sdata_out   <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (bclk_fall) begin
        sdata_out <= shreg[SLOT_W-1];
        lr_prev   <= lr_s2;
        if (left_bnd) begin
          frame_start <= 1'b1;
          underrun    <= enable && fifo_empty;
          if (enable && !fifo_empty) begin
            shreg  <= slot_word(rd_frame.left);
            hold_r <= rd_frame.right;
          end else begin
            shreg  <= '0;
            hold_r <= '0;
          end
        end else if (right_bnd) begin
          shreg <= slot_word(hold_r);
        end else begin
          shreg <= shreg << 1;
        end
      end
    end
  end

endmodule
